instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  input  1  one-cycle pulse that begins a program-load session; honoured only in IDLE.
REQ-004 SHALL have port base_addr  input  32  first IMem byte address; sampled when start is accepted.
REQ-005 SHALL have port in_valid  input  1  instruction-field bundle is valid.
REQ-006 SHALL have port in_ready  output  1  encoder accepts the bundle this cycle.
REQ-007 SHALL have port in_last  input  1  the bundle is the final instruction of the session.
REQ-008 SHALL have ports in_op (6), in_funct (6), in_rs, in_rt, in_rd, in_shamt (5 each), in_imm (16), in_target (26), all inputs carrying instruction fields.
REQ-009 SHALL have port imem_we  output  1  IMem write request.
REQ-010 SHALL have port imem_ready  input  1  IMem accepts the write this cycle.
REQ-011 SHALL have port imem_addr  output  32  IMem write byte address.
REQ-012 SHALL have port imem_wdata  output  32  encoded instruction word.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the session completes.
REQ-014 SHALL have port err_illegal  output  1  sticky flag set when an unsupported op_code is accepted.
REQ-015 SHALL have port word_count  output  16  number of words written in the current session.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE; start in IDLE -> RUN, loads the address counter from base_addr, clears word_count and err_illegal.
REQ-017 in_ready = (state == RUN) && (!imem_we || imem_ready); in_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-018 Accepted bundle (in_valid && in_ready) in cycle N SHALL appear as imem_we = 1 with its word in cycle N+1 (one-entry output register).
REQ-019 imem_we, imem_addr and imem_wdata SHALL hold stable while imem_we && !imem_ready.
REQ-020 On each write handshake (imem_we && imem_ready), the address counter SHALL increment by 4 (wrap modulo 2^32) and word_count by 1 (wrap modulo 2^16).
REQ-021 Back-to-back accept is allowed: a handshake and a new accept in the same cycle keep imem_we = 1 with the next word.
REQ-022 R-type (op 000000) SHALL encode as {op, rs, rt, rd, shamt, funct}.
REQ-023 The I-type ops LW, SW, BEQ, BNE, BLEZ, BGTZ, REGIMM (000001; BLTZ/BGEZ are selected by in_rt), ADDI, ADDIU, ANDI, ORI, XORI, SLTI and SLTIU SHALL encode as {op, rs, rt, imm}.
REQ-024 J (000010) SHALL encode as {op, target}.
REQ-025 Any other op: the bundle is consumed, no write is issued, address and count are unchanged, and err_illegal is set to 1 until the next start or reset.
REQ-026 An accepted bundle with in_last = 1 SHALL move RUN -> DRAIN; DRAIN -> DONE when there is no pending write (same cycle as the final handshake, or immediately if the last op is illegal).
REQ-027 DONE SHALL last exactly one cycle with done = 1, then go to IDLE; word_count and err_illegal hold their values in IDLE.
REQ-028 start asserted outside IDLE SHALL be ignored.

Reset
REQ-029 rst_n = 0 SHALL immediately force state IDLE, imem_we = 0, imem_addr = 0, imem_wdata = 0, done = 0, err_illegal = 0, word_count = 0, in_ready = 0; asserting it mid-session discards any pending write.

Structure
REQ-030 Op_code constants and the FSM state enum SHALL live in the shared package mips_isa_pkg, together with the op codes used by the control decoder.
REQ-031 The combinational field packing SHALL be the sub-module instr_pack (ports: op and fields in, word and illegal flag out).

Verification
REQ-032 start with base 0x00400000; ADD rs=1 rt=2 rd=3 funct=0x20 with last -> next cycle imem_wdata = 0x00221820 at addr 0x00400000; done one cycle after the handshake; word_count = 1.
REQ-033 LW rs=1 rt=2 imm=0x0004, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x0000010 (last) -> 0x8C220004, 0x1022FFFF, 0x08000010 at base, base+4 and base+8.
REQ-034 imem_ready held low 3 cycles on the first write -> word and address stable, in_ready = 0, no bundle lost; final word_count is correct.
REQ-035 op 0x3F sent between two valid words -> err_illegal = 1, only 2 writes at consecutive addresses; the next start clears the flag.
REQ-036 rst_n pulled low while imem_we = 1 -> outputs at reset values the same cycle; after release a new start at base 0x0 writes from address 0x0.
REQ-037 base 0xFFFFFFFC with two words -> second write goes to address 0x00000000.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and encoder FSM state type.
// Used by the instruction packer and the program-load encoder.
package mips_isa_pkg;

    localparam logic [5:0] OpRtype  = 6'h00;
    localparam logic [5:0] OpRegimm = 6'h01;
    localparam logic [5:0] OpJ      = 6'h02;
    localparam logic [5:0] OpBeq    = 6'h04;
    localparam logic [5:0] OpBne    = 6'h05;
    localparam logic [5:0] OpBlez   = 6'h06;
    localparam logic [5:0] OpBgtz   = 6'h07;
    localparam logic [5:0] OpAddi   = 6'h08;
    localparam logic [5:0] OpAddiu  = 6'h09;
    localparam logic [5:0] OpSlti   = 6'h0A;
    localparam logic [5:0] OpSltiu  = 6'h0B;
    localparam logic [5:0] OpAndi   = 6'h0C;
    localparam logic [5:0] OpOri    = 6'h0D;
    localparam logic [5:0] OpXori   = 6'h0E;
    localparam logic [5:0] OpLw     = 6'h23;
    localparam logic [5:0] OpSw     = 6'h2B;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } enc_state_e;

    // REGIMM shares the I-type layout; BLTZ/BGEZ live in the rt field.
    function automatic logic is_itype(logic [5:0] op);
        case (op)
            OpRegimm, OpBeq, OpBne, OpBlez, OpBgtz, OpAddi, OpAddiu,
            OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLw, OpSw: is_itype = 1'b1;
            default: is_itype = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of instruction fields into a 32-bit MIPS word.
// Flags any op code outside the supported R/I/J set as illegal.
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        if (op == OpRtype) begin
            word = {op, rs, rt, rd, shamt, funct};
        end else if (op == OpJ) begin
            word = {op, target};
        end else if (is_itype(op)) begin
            word = {op, rs, rt, imm};
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: accepts instruction-field bundles, packs them and
// streams the words into IMem through a one-entry output register.
module instr_encoder
    import mips_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        done,
    output logic        err_illegal,
    output logic [15:0] word_count
);

    enc_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;

    logic [31:0] packed_word;
    logic        illegal;
    logic        accept;
    logic        handshake;

    instr_pack u_pack (
        .op      (in_op),
        .funct   (in_funct),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .target  (in_target),
        .word    (packed_word),
        .illegal (illegal)
    );

    assign handshake = we_q && imem_ready;
    assign in_ready  = (state_q == StRun) && (!we_q || imem_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        count_d = count_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = base_addr;
                    count_d = 16'h0;
                    err_d   = 1'b0;
                end
            end
            StRun: begin
                if (accept && in_last) state_d = StDrain;
            end
            StDrain: begin
                if (!we_q || imem_ready) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (handshake) begin
            addr_d  = addr_q + 32'd4;
            count_d = count_q + 16'd1;
            we_d    = 1'b0;
        end

        // A new accept in the handshake cycle refills the register back-to-back.
        if (accept) begin
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                wdata_d = packed_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            count_q <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign done        = (state_q == StDone);
    assign err_illegal = err_q;
    assign word_count  = count_q;

endmodule
